clock_monitor: RTL and testbench
================================

Name: clock_monitor

Overview:
- Measures a divided clock (FSM_Clk, CVM_clk or ILA_Clk) in the main `clk` domain and checks it against an expected period.
- Captures the period and high time of the monitored clock, counted in `clk` cycles.
- Raises a sticky frequency-error flag when the period is out of tolerance, and a loss-of-clock flag when edges stop arriving.
- Instantiated next to the clock generator and read by software/ILA for bring-up and health status.

Parameters:
- CNT_W, 24: width of period/high-time counters and expected-period input.
- SYNC_STAGES, 2: synchronizer flops on mon_clk (legal range 2..4).
- TIMEOUT, 1048576: `clk` cycles without a mon_clk rising edge before declaring loss of clock.

Ports:
- clk  in  1  main system clock (post-IBUFGDS), sole clock of this block.
- rst_n  in  1  asynchronous active-low reset.
- mon_clk  in  1  monitored clock; asynchronous to clk, treated as data.
- enable  in  1  measurement enable.
- exp_period  in  CNT_W  expected period in clk cycles.
- tolerance  in  8  allowed absolute deviation, in clk cycles.
- err_clr  in  1  clears freq_err.
- period  out  CNT_W  last measured rising-to-rising interval.
- high_time  out  CNT_W  last measured rising-to-falling interval.
- meas_valid  out  1  one-cycle pulse when period updates.
- freq_err  out  1  sticky out-of-tolerance flag.
- clk_lost  out  1  level, high while in LOST state.

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, synchronizer 0, state IDLE.
- Sync and edge detect:
  - mon_clk passes through SYNC_STAGES flops, then one delay flop s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Edge detect latency is SYNC_STAGES+1 clk cycles after the mon_clk edge. The same latency applies to both edges, so measured intervals are unaffected.
- States: IDLE, ARM, MEASURE, LOST.
  - IDLE: counters held at 0. When enable=1, go to ARM.
  - ARM: wait for rise. On rise, go to MEASURE with cnt<=1 and hcnt<=1. No meas_valid on this first edge.
  - MEASURE: every cycle without rise, cnt<=cnt+1, saturating at all-ones.
    - hcnt increments while high-phase counting is active.
    - On fall: high_time<=hcnt, then stop hcnt.
    - On rise: period<=cnt; meas_valid=1 on the next cycle (registered); cnt<=1; hcnt<=1, restarting the high phase.
  - LOST: entered from ARM or MEASURE when cnt (ARM uses the same counter) reaches TIMEOUT.
    - clk_lost=1 while in LOST.
    - On rise: clk_lost<=0, cnt<=1, go to MEASURE. The first interval after recovery is not reported.
  - enable=0 in any state: go to IDLE next cycle; clk_lost<=0.
    - period and high_time hold their last values.
    - meas_valid stays 0; an edge in that same cycle is ignored.
- Error check: on each reported period, compute the absolute difference |period-exp_period| at CNT_W+1 bits with no wrap.
  - If it exceeds tolerance, set freq_err.
  - freq_err stays set until err_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - tolerance=0 requires an exact match.
- Saturation: if cnt saturates before TIMEOUT (only possible when TIMEOUT ≥ 2^CNT_W), LOST is still entered at TIMEOUT.
- exp_period and tolerance are sampled at compare time; changes mid-measurement take effect at the next rise.
- Reset mid-measurement: immediate return to reset values; no meas_valid pulse.
- Target implementation size: roughly 150–250 lines.

Test Plan:
- mon_clk toggling every 4 clk cycles (CVM rate), exp_period=8, tolerance=0, enable=1:
  - First meas_valid after the second rising edge; period=8, high_time=4.
  - freq_err stays 0.
- mon_clk toggling every 11 clk cycles (ILA rate), exp_period=20, tolerance=1:
  - period=22, high_time=11, freq_err=1 after the first meas_valid.
  - Then err_clr pulse coincident with the next out-of-tolerance measurement: freq_err remains 1.
- Same stimulus with tolerance=2: freq_err stays 0.
  - Asymmetric mon_clk (high 3, low 7): period=10, high_time=3.
- TIMEOUT overridden to 100, mon_clk stopped:
  - clk_lost=1 exactly 100 cycles after the last rise counted into cnt.
  - When mon_clk restarts, clk_lost clears on the first detected rise, and no meas_valid occurs until the following rise.
- enable dropped mid-period, then raised:
  - period/high_time retain previous values.
  - No meas_valid until two fresh rising edges have been seen.
  - rst_n asserted mid-period clears all outputs asynchronously.

Source files
------------

// File: rtl/clock_monitor.sv
`timescale 1ns/1ps
// clock_monitor: measures the period and high time of a divided clock in clk cycles,
// raises a sticky frequency-error flag and a loss-of-clock level.
module clock_monitor #(
  parameter int          CNT_W       = 24,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [7:0]       tolerance,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             freq_err,
  output logic             clk_lost
);

  // Separate timeout counter so loss of clock is still detected when TIMEOUT exceeds the cnt range.
  localparam int              TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_LOST} state_e;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;

  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hcnt;
  logic [TO_W-1:0]        r_tcnt;
  logic                   r_high_act;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high_time;
  logic                   r_meas_valid;
  logic                   r_freq_err;
  logic                   r_clk_lost;

  logic [CNT_W-1:0]       w_cnt_inc;
  logic [CNT_W-1:0]       w_hcnt_inc;
  logic                   w_timeout;
  logic [CNT_W:0]         w_per_ext;
  logic [CNT_W:0]         w_exp_ext;
  logic [CNT_W:0]         w_diff;
  logic                   w_out_of_tol;
  logic                   w_set_err;

  // NOTE: mon_clk is plain data here; the synchronizer is reset so the first edge is seen from a known 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], mon_clk};
      r_s_d  <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  assign w_cnt_inc  = (r_cnt == '1)  ? r_cnt  : r_cnt  + CNT_W'(1);
  assign w_hcnt_inc = (r_hcnt == '1) ? r_hcnt : r_hcnt + CNT_W'(1);
  assign w_timeout  = (r_tcnt == TO_LIMIT);

  // Absolute difference one bit wider than the operands so it can never wrap.
  assign w_per_ext    = {1'b0, r_cnt};
  assign w_exp_ext    = {1'b0, exp_period};
  assign w_diff       = (w_per_ext >= w_exp_ext) ? (w_per_ext - w_exp_ext) : (w_exp_ext - w_per_ext);
  assign w_out_of_tol = (w_diff > (CNT_W + 1)'(tolerance));
  assign w_set_err    = enable & (r_state == S_MEASURE) & w_rise & w_out_of_tol;

  // NOTE: every register below is state, so all updates are non-blocking; the last assignment in a cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_tcnt       <= '0;
      r_high_act   <= 1'b0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_freq_err   <= 1'b0;
      r_clk_lost   <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;

      if (w_set_err) begin
        r_freq_err <= 1'b1;
      end else if (err_clr) begin
        r_freq_err <= 1'b0;
      end

      if (!enable) begin
        r_state    <= S_IDLE;
        r_clk_lost <= 1'b0;
        r_cnt      <= '0;
        r_hcnt     <= '0;
        r_tcnt     <= '0;
        r_high_act <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt   <= '0;
            r_hcnt  <= '0;
            r_tcnt  <= '0;
            r_state <= S_ARM;
          end

          S_ARM: begin
            if (w_rise) begin
              r_state    <= S_MEASURE;
              r_cnt      <= CNT_W'(1);
              r_hcnt     <= CNT_W'(1);
              r_tcnt     <= TO_W'(1);
              r_high_act <= 1'b1;
            end else if (w_timeout) begin
              r_state    <= S_LOST;
              r_clk_lost <= 1'b1;
            end else begin
              r_cnt  <= w_cnt_inc;
              r_tcnt <= r_tcnt + TO_W'(1);
            end
          end

          S_MEASURE: begin
            if (w_rise) begin
              r_period     <= r_cnt;
              r_meas_valid <= 1'b1;
              r_cnt        <= CNT_W'(1);
              r_hcnt       <= CNT_W'(1);
              r_tcnt       <= TO_W'(1);
              r_high_act   <= 1'b1;
            end else if (w_timeout) begin
              r_state    <= S_LOST;
              r_clk_lost <= 1'b1;
              r_high_act <= 1'b0;
            end else begin
              r_cnt  <= w_cnt_inc;
              r_tcnt <= r_tcnt + TO_W'(1);
              if (w_fall && r_high_act) begin
                r_high_time <= r_hcnt;
                r_high_act  <= 1'b0;
              end else if (r_high_act) begin
                r_hcnt <= w_hcnt_inc;
              end
            end
          end

          S_LOST: begin
            // The interval that ends on the recovery edge is meaningless and is not reported.
            if (w_rise) begin
              r_state    <= S_MEASURE;
              r_clk_lost <= 1'b0;
              r_cnt      <= CNT_W'(1);
              r_hcnt     <= CNT_W'(1);
              r_tcnt     <= TO_W'(1);
              r_high_act <= 1'b1;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign freq_err   = r_freq_err;
  assign clk_lost   = r_clk_lost;

endmodule

// File: tb/tb_clock_monitor.sv
`timescale 1ns/1ps
// tb_clock_monitor: table-driven and randomized checks of clock_monitor against an
// interval-based reference model (edge times in clk cycles, queue of expected reports).
module tb_clock_monitor;

  localparam int          CW   = 24;
  localparam int          SYNC = 2;
  localparam int unsigned TO   = 100;
  localparam int          LAT  = SYNC + 1;

  logic          clk;
  logic          rst_n;
  logic          mon_clk;
  logic          enable;
  logic [CW-1:0] exp_period;
  logic [7:0]    tolerance;
  logic          err_clr;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          freq_err;
  logic          clk_lost;

  clock_monitor #(
    .CNT_W      (CW),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mon_clk   (mon_clk),
    .enable    (enable),
    .exp_period(exp_period),
    .tolerance (tolerance),
    .err_clr   (err_clr),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .freq_err  (freq_err),
    .clk_lost  (clk_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   hi;
    int   lo;
    int   n;
    int   expp;
    int   tol;
    int   per;
    int   ht;
    logic err;
  } vec_t;

  typedef struct {
    int due;
    int per;
    int hi;
  } meas_t;

  vec_t  vecs [8];
  meas_t exp_q [$];

  int   n_checks;
  int   n_errors;
  int   cyc;
  int   mv_count;
  int   last_rise;
  int   last_fall;
  logic have_rise;
  logic model_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clk cycle: inputs are changed only between step() calls (at the falling edge),
  // outputs are sampled at the falling edge after the active edge.
  task automatic step();
    logic  clr_edge;
    logic  set_now;
    meas_t m;
    int    d;
    clr_edge = err_clr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    set_now = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      m = exp_q.pop_front();
      check("meas_valid", 32'(meas_valid), 32'd1);
      check("period", 32'(period), m.per);
      check("high_time", 32'(high_time), m.hi);
      d = m.per - int'(exp_period);
      if (d < 0) d = -d;
      set_now = (d > int'(tolerance));
    end else begin
      check("no_meas_valid", 32'(meas_valid), 32'd0);
    end
    if (meas_valid) mv_count++;
    if (set_now) model_err = 1'b1;
    else if (clr_edge) model_err = 1'b0;
    check("freq_err", 32'(freq_err), 32'(model_err));
  endtask

  task automatic rstep();
    step();
    err_clr = ($urandom_range(0, 15) == 0);
  endtask

  // Drive mon_clk and record its edges; a rise closes an interval that is reported
  // LAT cycles later unless it exceeded TIMEOUT or measurement was not running.
  task automatic set_mon(input logic v);
    int d;
    if (v && !mon_clk) begin
      if (enable && have_rise) begin
        d = cyc - last_rise;
        if (d <= int'(TO)) exp_q.push_back('{due: cyc + LAT, per: d, hi: last_fall - last_rise});
      end
      last_rise = cyc;
      have_rise = enable;
    end else if (!v && mon_clk) begin
      last_fall = cyc;
    end
    mon_clk = v;
  endtask

  task automatic set_enable(input logic v);
    enable = v;
    if (!v) have_rise = 1'b0;
  endtask

  task automatic restart(input int e, input int t);
    set_enable(1'b0);
    repeat (2) step();
    set_mon(1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    repeat (5) step();
    exp_period = CW'(e);
    tolerance  = 8'(t);
    set_enable(1'b1);
    step();
  endtask

  // n full periods, then a closing rise so the last period is reported too.
  task automatic run_wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      set_mon(1'b1);
      repeat (hi) step();
      set_mon(1'b0);
      repeat (lo) step();
    end
    set_mon(1'b1);
    repeat (LAT + 1) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected under 20000", cyc);
    $fatal(1);
  end

  initial begin
    int r;
    int q;
    int mv0;

    //            hi  lo  n  expp tol  per  ht  err
    vecs[0] = '{  4,  4, 3,   8,   0,   8,  4, 1'b0};
    vecs[1] = '{ 11, 11, 3,  20,   1,  22, 11, 1'b1};
    vecs[2] = '{ 11, 11, 3,  20,   2,  22, 11, 1'b0};
    vecs[3] = '{  3,  7, 3,  10,   0,  10,  3, 1'b0};
    vecs[4] = '{ 50, 50, 2, 100,   0, 100, 50, 1'b0};
    vecs[5] = '{  1,  1, 4,   2,   0,   2,  1, 1'b0};
    vecs[6] = '{  5,  5, 3,  20, 255,  10,  5, 1'b0};
    vecs[7] = '{  9,  1, 3,   5,   4,  10,  9, 1'b1};

    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    mv_count   = 0;
    last_rise  = 0;
    last_fall  = 0;
    have_rise  = 1'b0;
    model_err  = 1'b0;
    rst_n      = 1'b0;
    mon_clk    = 1'b0;
    enable     = 1'b0;
    exp_period = '0;
    tolerance  = '0;
    err_clr    = 1'b0;

    repeat (3) step();
    check("rst_period", 32'(period), 32'd0);
    check("rst_high_time", 32'(high_time), 32'd0);
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_freq_err", 32'(freq_err), 32'd0);
    check("rst_clk_lost", 32'(clk_lost), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      restart(vecs[i].expp, vecs[i].tol);
      run_wave(vecs[i].hi, vecs[i].lo, vecs[i].n);
      check("row_period", 32'(period), vecs[i].per);
      check("row_high_time", 32'(high_time), vecs[i].ht);
      check("row_freq_err", 32'(freq_err), 32'(vecs[i].err));
      check("row_clk_lost", 32'(clk_lost), 32'd0);
      check("row_queue_drained", exp_q.size(), 32'd0);
    end

    // err_clr coincident with an out-of-tolerance report: set wins.
    restart(20, 1);
    run_wave(11, 11, 2);
    check("ila_err_set", 32'(freq_err), 32'd1);
    repeat (7) step();
    set_mon(1'b0);
    repeat (11) step();
    set_mon(1'b1);
    repeat (2) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("set_wins_mv", 32'(meas_valid), 32'd1);
    check("set_wins_err", 32'(freq_err), 32'd1);
    repeat (3) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_alone", 32'(freq_err), 32'd0);

    // Loss of clock exactly TIMEOUT cycles after the last counted rise, then recovery.
    restart(10, 0);
    run_wave(5, 5, 2);
    r = last_rise;
    set_mon(1'b0);
    while (cyc < r + LAT + int'(TO) + 5) begin
      step();
      check("clk_lost_timing", 32'(clk_lost), 32'(cyc >= r + LAT + int'(TO)));
    end
    q = cyc;
    mv0 = mv_count;
    set_mon(1'b1);
    step();
    step();
    check("lost_hold", 32'(clk_lost), 32'd1);
    step();
    check("lost_clear", 32'(clk_lost), 32'd0);
    check("lost_clear_cycle", cyc - q, LAT);
    repeat (2) step();
    set_mon(1'b0);
    repeat (5) step();
    check("no_mv_after_recovery", mv_count, mv0);
    set_mon(1'b1);
    repeat (LAT + 1) step();
    check("mv_after_recovery", mv_count, mv0 + 1);
    check("recovery_period", 32'(period), 32'd10);
    check("recovery_high_time", 32'(high_time), 32'd5);

    // Enable dropped mid-period: results hold, two fresh rises needed afterwards.
    restart(12, 0);
    run_wave(6, 6, 2);
    step();
    set_enable(1'b0);
    step();
    set_mon(1'b0);
    repeat (3) step();
    set_mon(1'b1);
    repeat (3) step();
    set_mon(1'b0);
    repeat (6) step();
    check("dis_period_hold", 32'(period), 32'd12);
    check("dis_high_hold", 32'(high_time), 32'd6);
    check("dis_clk_lost", 32'(clk_lost), 32'd0);
    mv0 = mv_count;
    set_enable(1'b1);
    repeat (2) step();
    set_mon(1'b1);
    repeat (4) step();
    set_mon(1'b0);
    repeat (4) step();
    check("en_one_rise_no_mv", mv_count, mv0);
    set_mon(1'b1);
    repeat (LAT + 1) step();
    check("en_two_rises_mv", mv_count, mv0 + 1);
    check("en_period", 32'(period), 32'd8);
    check("en_high_time", 32'(high_time), 32'd4);

    // Asynchronous reset in the middle of a high phase.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_period", 32'(period), 32'd0);
    check("async_rst_high", 32'(high_time), 32'd0);
    check("async_rst_mv", 32'(meas_valid), 32'd0);
    check("async_rst_err", 32'(freq_err), 32'd0);
    check("async_rst_lost", 32'(clk_lost), 32'd0);
    exp_q.delete();
    model_err = 1'b0;
    have_rise = 1'b0;
    mon_clk   = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    exp_period = CW'(8);
    tolerance  = 8'd0;
    step();
    run_wave(4, 4, 2);
    check("post_rst_period", 32'(period), 32'd8);
    check("post_rst_high", 32'(high_time), 32'd4);

    // Randomized intervals, expectations and clears against the model.
    restart(int'($urandom_range(2, 40)), int'($urandom_range(0, 6)));
    for (int i = 0; i < 60; i++) begin
      int hi;
      int lo;
      if (i % 10 == 9) begin
        exp_period = CW'($urandom_range(2, 40));
        tolerance  = 8'($urandom_range(0, 6));
      end
      hi = int'($urandom_range(1, 20));
      lo = int'($urandom_range(1, 20));
      set_mon(1'b1);
      repeat (hi) rstep();
      set_mon(1'b0);
      repeat (lo) rstep();
    end
    set_mon(1'b1);
    repeat (LAT + 1) rstep();
    err_clr = 1'b0;
    step();
    check("rand_queue_drained", exp_q.size(), 32'd0);
    check("rand_clk_lost", 32'(clk_lost), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
